// File: rtl/spi_matrix_slave.sv
`timescale 1ns/1ps
// spi_matrix_slave
// SPI slave that runs entirely in the clk domain. SCLK, MOSI and SS are
// synchronised and edge-detected. Each received word is pushed into a
// ROWS-deep history, and a free-running scan engine drives a multiplexed
// LED matrix from that history. The matrix rows are active-low and the
// columns are active-high.
// MISO returns a status word that decrements after every completed word.
// Optional build macro SPI_MATRIX_ECHO_EN: MISO instead echoes the previous
// completed rx word (0 after reset), and the decrementer is removed.
module spi_matrix_slave #(
    parameter int DATA_W   = 8,
    parameter int COLS     = 4,
    parameter int ROWS     = 3,
    parameter int SCAN_DIV = 150000,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              SS,
    output logic              MISO,
    output logic [COLS-1:0]   cols,
    output logic [ROWS-1:0]   rows,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data
);

    localparam int   BIT_W       = $clog2(DATA_W);
    localparam int   IDX_W       = $clog2(ROWS);
    localparam int   CNT_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic IDLE_LVL    = (CPOL != 0);
    localparam logic SAMPLE_LEAD = (CPHA == 0);

`ifdef SPI_MATRIX_ECHO_EN
    localparam logic [DATA_W-1:0] TX_RST = '0;
`else
    localparam logic [DATA_W-1:0] TX_RST = '1;
`endif

    // Synchroniser chain: _p0/_p1 are the two-flop synchroniser, and _p2 is the edge history.
    logic sclk_p0, sclk_p1, sclk_p2;
    logic ss_p0, ss_p1, ss_p2;
    logic mosi_p0, mosi_p1;

    // Decoded events, all aligned with the _p1 stage.
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic ss_fall, word_done;
    logic [DATA_W-1:0] rx_full;
    logic [DATA_W-1:0] tx_next;

    // SPI shift state
    logic [DATA_W-2:0] shift_rx;
    logic [DATA_W-1:0] shift_tx;
    logic [DATA_W-1:0] tx_word;
    logic [BIT_W-1:0]  bit_cnt;
    logic              miso_q;

    // Only the column slice of each word is ever displayed, so only that slice is kept.
    logic [COLS-1:0]   hist [ROWS];

    // Scan engine state
    logic [CNT_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic [ROWS-1:0]   row_sel;

`ifndef SPI_MATRIX_ECHO_EN
    // Status word steps down by one per completed word and wraps 0 -> all ones.
    function automatic logic [DATA_W-1:0] dec_wrap(input logic [DATA_W-1:0] w);
        return w - DATA_W'(1);
    endfunction
`endif

    // Bring the asynchronous SPI pins into the clk domain; the idle levels keep edges quiet out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_p0 <= IDLE_LVL;
            sclk_p1 <= IDLE_LVL;
            sclk_p2 <= IDLE_LVL;
            ss_p0   <= 1'b1;
            ss_p1   <= 1'b1;
            ss_p2   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= SCLK;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            ss_p0   <= SS;
            ss_p1   <= ss_p0;
            ss_p2   <= ss_p1;
            mosi_p0 <= MOSI;
            mosi_p1 <= mosi_p0;
        end
    end

    // Stage p1 -> event decode
    assign lead_edge   = (sclk_p1 != IDLE_LVL) && (sclk_p2 == IDLE_LVL);
    assign trail_edge  = (sclk_p1 == IDLE_LVL) && (sclk_p2 != IDLE_LVL);
    assign sample_edge = SAMPLE_LEAD ? lead_edge  : trail_edge;
    assign shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;
    assign ss_fall     = ss_p2 && !ss_p1;
    assign rx_full     = {shift_rx, mosi_p1};
    assign word_done   = !ss_p1 && !ss_fall && sample_edge
                         && (bit_cnt == BIT_W'(DATA_W - 1));

`ifdef SPI_MATRIX_ECHO_EN
    assign tx_next = rx_full;
`else
    assign tx_next = dec_wrap(tx_word);
`endif

    // SPI receive/transmit shifting, word completion and the MISO register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_rx <= '0;
            shift_tx <= TX_RST;
            tx_word  <= TX_RST;
            bit_cnt  <= '0;
            miso_q   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (ss_p1) begin
                // Deselected: any partial word is dropped, and SCLK is ignored.
                bit_cnt <= '0;
                miso_q  <= 1'b0;
            end else if (ss_fall) begin
                bit_cnt <= '0;
                if (SAMPLE_LEAD) begin
                    // The MSB must already be on the line before the first sampling edge.
                    miso_q   <= tx_word[DATA_W-1];
                    shift_tx <= {tx_word[DATA_W-2:0], 1'b0};
                end else begin
                    shift_tx <= tx_word;
                end
            end else begin
                if (sample_edge) begin
                    shift_rx <= rx_full[DATA_W-2:0];
                    if (word_done) begin
                        bit_cnt  <= '0;
                        rx_valid <= 1'b1;
                        rx_data  <= rx_full;
                        tx_word  <= tx_next;
                        // Reloaded unshifted: the next shift edge presents the new MSB for back-to-back words.
                        shift_tx <= tx_next;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (shift_edge) begin
                    miso_q   <= shift_tx[DATA_W-1];
                    shift_tx <= {shift_tx[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    assign MISO = miso_q;

    // History FIFO: the oldest entry is at index 0 and the newest word enters at ROWS-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < ROWS; k++) begin
                hist[k] <= '0;
            end
        end else if (word_done) begin
            for (int k = 0; k < ROWS - 1; k++) begin
                hist[k] <= hist[k+1];
            end
            hist[ROWS-1] <= rx_full[COLS-1:0];
        end
    end

    // One-cold row pattern for the row that the scan engine loads next.
    always_comb begin
        row_sel           = '1;
        row_sel[scan_idx] = 1'b0;
    end

    // Free-running scan: each row dwells for SCAN_DIV cycles, and the history is read before any same-cycle push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            rows     <= '1;
            cols     <= '0;
        end else if (scan_cnt == '0) begin
            scan_cnt <= CNT_W'(SCAN_DIV - 1);
            rows     <= row_sel;
            cols     <= hist[scan_idx];
            scan_idx <= (scan_idx == IDX_W'(ROWS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt - 1'b1;
        end
    end

endmodule

// File: doc/spi_matrix_slave.md
Name: spi_matrix_slave

Overview:
- Parametrised SPI slave that receives words into a ROWS-deep history and drives a time-multiplexed LED matrix (active-low row select, active-high column data) from that history.
- Returns a decrementing status word on MISO.
- Next generation of the board's SPI receiver. Everything runs in the clk domain: SCLK, MOSI and SS are synchronised and edge-detected, not used as clocks.
- Configurable word width, matrix size, scan rate and all four SPI modes.

Parameters:
- DATA_W, 8: SPI word width in bits, MSB first.
- COLS, 4: column outputs; the low COLS bits of each history word drive them. COLS <= DATA_W.
- ROWS, 3: history depth and row-select count; must be >= 2.
- SCAN_DIV, 150000: clk cycles per row dwell.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 means sample on the leading edge; 1 means sample on the trailing edge.

Ports:
- clk  in  1  system clock; must be >= 4x SCLK frequency.
- rst_n  in  1  synchronous active-low reset.
- SCLK  in  1  SPI clock from master, asynchronous.
- MOSI  in  1  master data, asynchronous.
- SS  in  1  active-low slave select, asynchronous.
- MISO  out  1  slave data.
- cols  out  COLS  column drive, active high.
- rows  out  ROWS  row select, active low, one-cold.
- rx_valid  out  1  one-cycle pulse when a full word is received.
- rx_data  out  DATA_W  last received word; held until the next word completes.

Behaviour:
- Reset is synchronous, active-low, sampled on the rising edge of clk. It is honoured in any state, including mid-frame. Reset values:
  - rows = all ones; cols = 0.
  - rx_valid = 0; rx_data = 0; MISO = 0.
  - History all 0; tx_word = all ones.
  - Bit counter = 0; scan index = 0; scan counter = 0.
- Input path: SCLK, MOSI and SS each pass through a 2-FF synchroniser, plus one extra register for edge detection.
  - Leading edge = SCLK transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
- Frame start: synchronised SS falling loads shift_tx <= tx_word and bit counter <= 0.
  - CPHA=0: MISO <= tx_word MSB in the same cycle.
  - CPHA=1: MISO is updated on the first shift edge.
- Sample edge with SS low: shift_rx <= {shift_rx[DATA_W-2:0], MOSI_sync}; bit counter increments.
- Shift edge with SS low: MISO <= next bit of shift_tx.
  - Skip the first shift edge of a word when CPHA=0; that bit was already presented at frame start.
- Word complete (DATA_W-th sample edge):
  - Next cycle: rx_valid = 1 for exactly one cycle; rx_data = received word.
  - History shifts: entry k <= entry k+1; entry ROWS-1 <= new word.
  - tx_word <= tx_word - 1, modulo 2^DATA_W (0 wraps to all ones).
  - Bit counter <= 0 and shift_tx reloads from the updated tx_word, so back-to-back words within one SS-low window are supported.
- SS rising with a partial word: discard it. No rx_valid, no history change, tx_word unchanged, bit counter <= 0.
- SS high: MISO = 0; SCLK edges are ignored.
- Scan engine, free-running and independent of SPI:
  - When scan counter = 0: counter <= SCAN_DIV-1; rows <= ~(1 << idx); cols <= history[idx][COLS-1:0]; idx <= (idx == ROWS-1) ? 0 : idx+1.
  - Otherwise the counter decrements.
  - First row update occurs in the first clk cycle after reset release.
- Same-cycle history push and scan load: the scan uses the pre-push history (registered read).

Optional Feature:
- Macro: SPI_MATRIX_ECHO_EN.
- Defined: each frame's MISO payload is the previous completed rx word (0 after reset), i.e. loopback echo; the tx_word decrementer is removed.
- Undefined: MISO carries the decrementing tx_word as described above.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0), DATA_W=8: one frame of 0xA5 -> rx_valid single pulse, rx_data=0xA5, MISO bits 1111_1111. Second frame -> MISO returns 0xFE.
- SCAN_DIV=4, ROWS=3: send 0x01, 0x02, 0x03 -> successive rows=110/101/011 with cols=1/2/3, each held 4 cycles, pattern repeating.
- Send 5 bits, then raise SS; then send a full 0x3C frame -> no pulse for the partial word; rx_data=0x3C; history gains only 0x3C; MISO of the 0x3C frame = 0xFF.
- Mode 3 (CPOL=1, CPHA=1): two back-to-back words 0x81, 0x7E in one SS-low window -> two rx_valid pulses, rx_data 0x81 then 0x7E; MISO words 0xFF then 0xFE.
- Assert rst_n=0 after bit 4 of a frame -> all reset values (rows=111, cols=0, history 0). The next full frame 0x55 is received correctly.
- 256 completed frames -> MISO word wraps 0x00 back to 0xFF. With SPI_MATRIX_ECHO_EN: send 0x12, then 0x34 -> MISO words 0x00, then 0x12.
